// File: rtl/micalog_counter_pkg.sv
// Shared constants and helpers for the prescaled up/down counter.
// Mode selectors and a clog2 that never returns less than one bit.
package micalog_counter_pkg;

  localparam int MODE_WRAP     = 0;
  localparam int MODE_SATURATE = 1;

  function automatic int clog2_min1(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'(1) << i) < 64'(n)) r = i + 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/tick_divider.sv
// Prescaler: counts enabled cycles and flags every PRESCALE-th one.
// A clear discards the phase and suppresses that cycle's tick.
module tick_divider
  import micalog_counter_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic clock,
  input  logic reset_,
  input  logic enable,
  input  logic clear,
  output logic tick
);

  localparam int DW = clog2_min1(PRESCALE);
  localparam logic [DW-1:0] LAST = DW'(PRESCALE - 1);

  logic [DW-1:0] div;

  assign tick = enable && !clear && (div == LAST);

  always_ff @(posedge clock) begin
    if (!reset_) begin
      div <= '0;
    end else if (clear || tick) begin
      div <= '0;
    end else if (enable) begin
      div <= div + 1'b1;
    end
  end

endmodule

// File: rtl/updown_prescaled_counter.sv
// Up/down counter advanced by a prescaled tick, with wrap or clamp
// at the bounds and a load that overrides counting.
module updown_prescaled_counter
  import micalog_counter_pkg::*;
#(
  parameter int     WIDTH    = 16,
  parameter int     PRESCALE = 1,
  parameter longint STEP     = 1,
  parameter int     SATURATE = MODE_WRAP
) (
  input  logic             clock,
  input  logic             reset_,
  input  logic             enable,
  input  logic             up,
  input  logic             load_,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] counter,
  output logic             tick,
  output logic             wrap,
  output logic             saturated,
  output logic             at_max,
  output logic             at_min
);

  localparam logic [WIDTH:0]   STEP_X = (WIDTH + 1)'(STEP);
  localparam logic [WIDTH-1:0] MAX    = '1;

  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;
  logic           over;
  logic           under;

  tick_divider #(
    .PRESCALE(PRESCALE)
  ) u_div (
    .clock (clock),
    .reset_(reset_),
    .enable(enable),
    .clear (!load_),
    .tick  (tick)
  );

  // One extra bit keeps carry/borrow visible for the bound checks.
  assign sum   = {1'b0, counter} + STEP_X;
  assign diff  = {1'b0, counter} - STEP_X;
  assign over  = sum[WIDTH];
  assign under = diff[WIDTH];

  assign at_max = (counter == MAX);
  assign at_min = (counter == '0);

  always_ff @(posedge clock) begin
    if (!reset_) begin
      counter   <= '0;
      wrap      <= 1'b0;
      saturated <= 1'b0;
    end else if (!load_) begin
      counter   <= load_value;
      wrap      <= 1'b0;
      saturated <= 1'b0;
    end else if (tick) begin
      if (SATURATE == MODE_SATURATE) begin
        wrap <= 1'b0;
        if (up) begin
          counter   <= over ? MAX : sum[WIDTH-1:0];
          saturated <= over;
        end else begin
          counter   <= under ? '0 : diff[WIDTH-1:0];
          saturated <= under;
        end
      end else begin
        counter   <= up ? sum[WIDTH-1:0] : diff[WIDTH-1:0];
        wrap      <= up ? over : under;
        saturated <= 1'b0;
      end
    end else begin
      wrap <= 1'b0;
    end
  end

endmodule

// File: tb/tb_updown_prescaled_counter.sv
// Bench for updown_prescaled_counter: directed corner sequences,
// a vector table and a randomized run against a reference model.
module tb_updown_prescaled_counter;

  logic        clock = 1'b0;
  logic        reset_;
  logic        enable;
  logic        up;
  logic        load_;
  logic [15:0] load_value;

  always #5 clock = ~clock;

  int nvec = 0;
  int nerr = 0;

  logic [3:0]  c1, c2, c3;
  logic [15:0] c4;
  logic [7:0]  c5, c6;
  logic [4:0]  cr0, cr1;
  logic t1, w1, s1, mx1, mn1;
  logic t2, w2, s2, mx2, mn2;
  logic t3, w3, s3, mx3, mn3;
  logic t4, w4, s4, mx4, mn4;
  logic t5, w5, s5, mx5, mn5;
  logic t6, w6, s6, mx6, mn6;
  logic tr0, wr0, sr0, mxr0, mnr0;
  logic tr1, wr1, sr1, mxr1, mnr1;

  updown_prescaled_counter #(.WIDTH(4), .PRESCALE(1), .STEP(1), .SATURATE(0)) u1 (
    .clock(clock), .reset_(reset_), .enable(enable), .up(up), .load_(load_),
    .load_value(load_value[3:0]), .counter(c1), .tick(t1), .wrap(w1),
    .saturated(s1), .at_max(mx1), .at_min(mn1));

  updown_prescaled_counter #(.WIDTH(4), .PRESCALE(3), .STEP(1), .SATURATE(0)) u2 (
    .clock(clock), .reset_(reset_), .enable(enable), .up(up), .load_(load_),
    .load_value(load_value[3:0]), .counter(c2), .tick(t2), .wrap(w2),
    .saturated(s2), .at_max(mx2), .at_min(mn2));

  updown_prescaled_counter #(.WIDTH(4), .PRESCALE(1), .STEP(5), .SATURATE(1)) u3 (
    .clock(clock), .reset_(reset_), .enable(enable), .up(up), .load_(load_),
    .load_value(load_value[3:0]), .counter(c3), .tick(t3), .wrap(w3),
    .saturated(s3), .at_max(mx3), .at_min(mn3));

  updown_prescaled_counter #(.WIDTH(16), .PRESCALE(2), .STEP(1), .SATURATE(0)) u4 (
    .clock(clock), .reset_(reset_), .enable(enable), .up(up), .load_(load_),
    .load_value(load_value), .counter(c4), .tick(t4), .wrap(w4),
    .saturated(s4), .at_max(mx4), .at_min(mn4));

  updown_prescaled_counter #(.WIDTH(8), .PRESCALE(1), .STEP(3), .SATURATE(0)) u5 (
    .clock(clock), .reset_(reset_), .enable(enable), .up(up), .load_(load_),
    .load_value(load_value[7:0]), .counter(c5), .tick(t5), .wrap(w5),
    .saturated(s5), .at_max(mx5), .at_min(mn5));

  updown_prescaled_counter #(.WIDTH(8), .PRESCALE(4), .STEP(1), .SATURATE(0)) u6 (
    .clock(clock), .reset_(reset_), .enable(enable), .up(up), .load_(load_),
    .load_value(load_value[7:0]), .counter(c6), .tick(t6), .wrap(w6),
    .saturated(s6), .at_max(mx6), .at_min(mn6));

  updown_prescaled_counter #(.WIDTH(5), .PRESCALE(3), .STEP(7), .SATURATE(0)) ur0 (
    .clock(clock), .reset_(reset_), .enable(enable), .up(up), .load_(load_),
    .load_value(load_value[4:0]), .counter(cr0), .tick(tr0), .wrap(wr0),
    .saturated(sr0), .at_max(mxr0), .at_min(mnr0));

  updown_prescaled_counter #(.WIDTH(5), .PRESCALE(2), .STEP(6), .SATURATE(1)) ur1 (
    .clock(clock), .reset_(reset_), .enable(enable), .up(up), .load_(load_),
    .load_value(load_value[4:0]), .counter(cr1), .tick(tr1), .wrap(wr1),
    .saturated(sr1), .at_max(mxr1), .at_min(mnr1));

  typedef struct {
    logic        ld;
    logic [15:0] lv;
    logic        en;
    logic        dir;
    logic        tk;
    logic [3:0]  cnt;
    logic        sat;
    logic        wr;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: actual %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset_     = 1'b0;
    enable     = 1'b0;
    load_      = 1'b1;
    up         = 1'b1;
    load_value = '0;
    step();
    reset_ = 1'b1;
  endtask

  // Reference model state for the two randomized instances.
  int  rp[2]   = '{3, 2};
  int  rs[2]   = '{7, 6};
  bit  rsat[2] = '{1'b0, 1'b1};
  int  rm      = 32;
  int  mc[2];
  int  ph[2];
  bit  mw[2];
  bit  ms[2];
  bit  mt[2];

  initial begin
    reset_     = 1'b0;
    enable     = 1'b0;
    up         = 1'b1;
    load_      = 1'b1;
    load_value = '0;

    tbl[0] = '{1'b0, 16'd12, 1'b1, 1'b1, 1'b0, 4'd12, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 16'd0,  1'b1, 1'b1, 1'b1, 4'd15, 1'b1, 1'b0};
    tbl[2] = '{1'b1, 16'd0,  1'b1, 1'b0, 1'b1, 4'd10, 1'b0, 1'b0};
    tbl[3] = '{1'b1, 16'd0,  1'b1, 1'b0, 1'b1, 4'd5,  1'b0, 1'b0};
    tbl[4] = '{1'b1, 16'd0,  1'b1, 1'b0, 1'b1, 4'd0,  1'b0, 1'b0};
    tbl[5] = '{1'b1, 16'd0,  1'b1, 1'b0, 1'b1, 4'd0,  1'b1, 1'b0};
    tbl[6] = '{1'b1, 16'd0,  1'b0, 1'b0, 1'b0, 4'd0,  1'b1, 1'b0};
    tbl[7] = '{1'b0, 16'd3,  1'b1, 1'b1, 1'b0, 4'd3,  1'b0, 1'b0};

    // Plain wrap counting, PRESCALE=1.
    do_reset();
    enable = 1'b1;
    up     = 1'b1;
    #1;
    chk("s1 reset counter", c1, 0);
    chk("s1 reset at_min", mn1, 1);
    chk("s1 reset at_max", mx1, 0);
    chk("s1 reset tick", t1, 1);
    chk("s1 reset wrap", w1, 0);
    for (int i = 1; i <= 16; i++) begin
      step();
      chk("s1 counter", c1, i % 16);
      chk("s1 wrap", w1, i == 16);
    end

    // PRESCALE=3, continuous enable.
    do_reset();
    enable = 1'b1;
    for (int k = 1; k <= 9; k++) begin
      #1;
      chk("s2a tick", t2, (k % 3) == 0);
      step();
      chk("s2a counter", c2, k / 3);
    end

    // PRESCALE=3 with enable dropped on cycles 5 and 6.
    do_reset();
    for (int k = 1; k <= 8; k++) begin
      enable = !(k == 5 || k == 6);
      #1;
      chk("s2b tick", t2, (k == 3) || (k == 8));
      step();
    end
    chk("s2b counter", c2, 2);

    // Saturating table, STEP=5.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      load_      = tbl[i].ld;
      load_value = tbl[i].lv;
      enable     = tbl[i].en;
      up         = tbl[i].dir;
      #1;
      chk("s3 tick", t3, tbl[i].tk);
      step();
      chk("s3 counter", c3, tbl[i].cnt);
      chk("s3 saturated", s3, tbl[i].sat);
      chk("s3 wrap", w3, tbl[i].wr);
    end
    load_ = 1'b1;

    // Load colliding with a tick, PRESCALE=2.
    do_reset();
    enable = 1'b1;
    up     = 1'b1;
    #1;
    chk("s4 tick c1", t4, 0);
    step();
    load_      = 1'b0;
    load_value = 16'hFFFF;
    #1;
    chk("s4 tick on load", t4, 0);
    step();
    chk("s4 load counter", c4, 16'hFFFF);
    chk("s4 load wrap", w4, 0);
    load_ = 1'b1;
    #1;
    chk("s4 div cleared", t4, 0);
    step();
    chk("s4 hold counter", c4, 16'hFFFF);
    #1;
    chk("s4 tick", t4, 1);
    step();
    chk("s4 wrapped counter", c4, 0);
    chk("s4 wrap", w4, 1);
    step();
    chk("s4 wrap drop", w4, 0);

    // Down wrap with STEP=3 from 2.
    do_reset();
    load_      = 1'b0;
    load_value = 16'd2;
    step();
    load_  = 1'b1;
    enable = 1'b1;
    up     = 1'b0;
    #1;
    chk("s5 tick", t5, 1);
    chk("s5 at_min", mn5, 0);
    step();
    chk("s5 counter", c5, 8'hFF);
    chk("s5 wrap", w5, 1);
    chk("s5 at_max", mx5, 1);

    // Reset mid-prescale, PRESCALE=4.
    do_reset();
    load_      = 1'b0;
    load_value = 16'h37;
    step();
    chk("s6 load", c6, 8'h37);
    load_  = 1'b1;
    enable = 1'b1;
    up     = 1'b1;
    step();
    step();
    reset_     = 1'b0;
    load_      = 1'b0;
    load_value = 16'h55;
    step();
    reset_ = 1'b1;
    load_  = 1'b1;
    chk("s6 counter", c6, 0);
    chk("s6 wrap", w6, 0);
    chk("s6 saturated", s6, 0);
    chk("s6 at_min", mn6, 1);
    chk("s6 at_max", mx6, 0);
    for (int k = 1; k <= 4; k++) begin
      #1;
      chk("s6 tick", t6, k == 4);
      step();
    end
    chk("s6 counter after", c6, 1);

    // Randomized run against the reference model.
    do_reset();
    for (int j = 0; j < 2; j++) begin
      mc[j] = 0;
      ph[j] = 0;
      mw[j] = 1'b0;
      ms[j] = 1'b0;
    end
    for (int n = 0; n < 400; n++) begin
      reset_     = ($urandom_range(0, 49) != 0);
      load_      = ($urandom_range(0, 9) != 0);
      enable     = ($urandom_range(0, 3) != 0);
      up         = 1'($urandom_range(0, 1));
      load_value = 16'($urandom);
      #1;
      for (int j = 0; j < 2; j++) begin
        mt[j] = enable && load_ && (ph[j] == rp[j] - 1);
        chk("rnd tick", (j == 0) ? tr0 : tr1, mt[j]);
        chk("rnd at_max", (j == 0) ? mxr0 : mxr1, mc[j] == rm - 1);
        chk("rnd at_min", (j == 0) ? mnr0 : mnr1, mc[j] == 0);
        if (!reset_) begin
          mc[j] = 0;
          ph[j] = 0;
          mw[j] = 1'b0;
          ms[j] = 1'b0;
        end else if (!load_) begin
          mc[j] = int'(load_value) % rm;
          ph[j] = 0;
          mw[j] = 1'b0;
          ms[j] = 1'b0;
        end else if (mt[j]) begin
          int nv;
          bit oob;
          nv  = up ? mc[j] + rs[j] : mc[j] - rs[j];
          oob = (nv < 0) || (nv >= rm);
          if (rsat[j]) begin
            ms[j] = oob;
            mw[j] = 1'b0;
            mc[j] = (nv < 0) ? 0 : ((nv >= rm) ? rm - 1 : nv);
          end else begin
            mw[j] = oob;
            mc[j] = ((nv % rm) + rm) % rm;
          end
          ph[j] = 0;
        end else begin
          mw[j] = 1'b0;
          if (enable) ph[j] = ph[j] + 1;
        end
      end
      step();
      chk("rnd0 counter", cr0, mc[0]);
      chk("rnd0 wrap", wr0, mw[0]);
      chk("rnd0 saturated", sr0, ms[0]);
      chk("rnd1 counter", cr1, mc[1]);
      chk("rnd1 wrap", wr1, mw[1]);
      chk("rnd1 saturated", sr1, ms[1]);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/updown_prescaled_counter.md
UPDOWN_PRESCALED_COUNTER -- requirements
Module: updown_prescaled_counter

Interface
REQ-001 The block SHALL have these parameters:
- WIDTH, default 16, counter width in bits, 2..32.
- PRESCALE, default 1, number of enabled cycles per count tick, 1..65535.
- STEP, default 1, increment per tick, 1..2^WIDTH-1.
- SATURATE, default 0; 0 = wrap modulo 2^WIDTH, 1 = clamp at bounds.

REQ-002 The block SHALL have these ports (one clock; reset synchronous, active-low):
- clock  input  1  sole clock; all state changes on its rising edge.
- reset_  input  1  synchronous active-low reset.
- enable  input  1  advances the prescaler when high.
- up  input  1  count direction; 1 = up, 0 = down; sampled on the tick cycle.
- load_  input  1  active-low synchronous load.
- load_value  input  WIDTH  value taken when load_ is low.
- counter  output  WIDTH  registered count.
- tick  output  1  combinational; high when the current cycle is a count cycle.
- wrap  output  1  registered one-cycle pulse on modulo wrap (SATURATE=0 only).
- saturated  output  1  registered flag; last tick was clamped (SATURATE=1 only).
- at_max  output  1  combinational; counter == 2^WIDTH-1.
- at_min  output  1  combinational; counter == 0.

Function
REQ-003 The prescaler SHALL be a register div, width ceil(log2(PRESCALE)) (minimum 1), counting 0..PRESCALE-1 while enable is high, and holding while enable is low.
REQ-004 tick SHALL equal enable && (div == PRESCALE-1) && load_; with PRESCALE=1, tick SHALL equal enable && load_.
REQ-005 On a tick cycle div SHALL return to 0, and counter SHALL update at the same edge, so an update lands exactly 1 clock after the tick cycle.
REQ-006 Up tick, SATURATE=0: counter <= (counter+STEP) mod 2^WIDTH; wrap <= 1 if and only if the unbounded sum >= 2^WIDTH.
REQ-007 Down tick, SATURATE=0: counter <= (counter-STEP) mod 2^WIDTH; wrap <= 1 if and only if STEP > counter.
REQ-008 SATURATE=1 clamps instead of wrapping:
- Up tick: counter <= min(counter+STEP, 2^WIDTH-1).
- Down tick: counter <= max(counter-STEP, 0).
- saturated <= 1 if clamping occurred, else 0.
- wrap SHALL stay 0.
REQ-009 Overflow detection SHALL use WIDTH+1-bit arithmetic; no truncation before the compare.
REQ-010 wrap SHALL be high for exactly the one cycle following the wrapping update, and SHALL be 0 on every non-tick cycle.
REQ-011 saturated SHALL hold its value between ticks and update only on a tick or a load.
REQ-012 A load cycle (load_ == 0) SHALL take priority over enable and tick:
- counter <= load_value;
- div <= 0;
- wrap <= 0;
- saturated <= 0.
REQ-013 When load_ and a would-be tick coincide, the tick SHALL be discarded, with no count and no wrap.
REQ-014 The up input SHALL only be sampled on tick cycles; a direction change between ticks has no effect.
REQ-015 When enable falls mid-prescale, div SHALL be preserved, and counting resumes from that phase when enable rises again.

Reset
REQ-016 When reset_ is 0 at a rising clock edge, the block SHALL set counter=0, div=0, wrap=0 and saturated=0; reset SHALL override load_ and enable.
REQ-017 Directly after reset, at_min SHALL be 1 and at_max and tick SHALL follow REQ-004 and REQ-023.
REQ-018 Reset asserted mid-prescale SHALL discard the prescale phase; the first tick after release SHALL occur on the PRESCALE-th enabled cycle.

Structure
REQ-019 A package micalog_counter_pkg SHALL hold the mode constants MODE_WRAP=0 and MODE_SATURATE=1, plus a clog2-with-minimum-1 helper function.
REQ-020 The prescaler SHALL be a sub-module tick_divider with ports clock, reset_, enable, clear, tick and parameter PRESCALE.
REQ-021 The counter datapath, flag registers and at_max/at_min decode SHALL sit in the top module; there SHALL be no other sub-modules.
REQ-022 The design SHALL have no latches, no clocks derived from data, and a single clock domain.
REQ-023 at_max, at_min and tick SHALL be purely combinational from registers and inputs; all other outputs SHALL be registered.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- WIDTH=4, PRESCALE=1, SATURATE=0, enable=1, up=1 from reset, 16 cycles -> counter 1..15 then 0; wrap high only the cycle counter shows 0.
- WIDTH=4, PRESCALE=3, enable=1, up=1 -> counter increments every 3rd cycle; tick high on cycles 3, 6, 9; enable low for 2 cycles after cycle 4 delays the next tick to cycle 8.
- WIDTH=4, SATURATE=1, STEP=5, load 12, up=1 tick -> counter=15, saturated=1, wrap=0; down ticks -> 10, 5, 0, 0, with saturated=1 only on the last.
- WIDTH=16, load_=0 with load_value=0xFFFF coinciding with a tick -> counter=0xFFFF, no wrap, div=0; next up tick -> 0x0000 with wrap=1.
- WIDTH=8, down from 2 with STEP=3, SATURATE=0 -> counter=0xFF, wrap=1, at_max=1.
- reset_ low during prescale phase 2 of PRESCALE=4 -> all outputs 0, at_min=1; first tick after release on the 4th enabled cycle.
